// File: rtl/ram_port_master.sv
// Request initiator for one port of a latency-configurable RAM: issues reads/writes,
// captures read data after RD_LATENCY and returns it in order through a response FIFO.
module ram_port_master #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int RD_LATENCY = 2,
  parameter int WR_LATENCY = 1,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_ram_en,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_din,
  input  logic [DATA_WIDTH-1:0] i_ram_dout,
  output logic                  o_busy
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int HL = (WR_LATENCY > 1) ? WR_LATENCY - 1 : 1;

  logic                  ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
  logic [RD_LATENCY-1:0] tag_q, tag_d;
  logic [CW-1:0]         credits_q, credits_d, count_q, count_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
  logic                  hazard, hist_any, accept, rd_accept, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credits count reads in flight plus queued responses, so a full FIFO can never be pushed.
  assign o_req_ready = i_rst_n & ~(~i_req_we & (credits_q == CW'(RSP_DEPTH)))
                               & ~(~i_req_we & hazard);
  assign accept      = i_req_valid & o_req_ready;
  assign rd_accept   = accept & ~i_req_we;
  assign push        = tag_q[RD_LATENCY-1];
  assign o_rsp_valid = (count_q != '0);
  assign pop         = o_rsp_valid & i_rsp_ready;
  assign o_rsp_rdata = o_rsp_valid ? fifo_mem[rd_ptr_q] : '0;
  assign o_busy      = (credits_q != '0) | (ram_en_q & ram_we_q) | hist_any;
  assign o_ram_en    = ram_en_q;
  assign o_ram_we    = ram_we_q;
  assign o_ram_addr  = ram_addr_q;
  assign o_ram_din   = ram_din_q;

  always_comb begin
    ram_en_d   = accept;
    ram_we_d   = accept & i_req_we;
    ram_addr_d = accept ? i_req_addr : ram_addr_q;
    ram_din_d  = accept ? i_req_wdata : ram_din_q;
    tag_d[0]   = ram_en_q & ~ram_we_q;
    for (int i = 1; i < RD_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    credits_d  = credits_q + CW'(rd_accept) - CW'(pop);
    count_d    = count_q + CW'(push) - CW'(pop);
    rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ram_en_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      tag_q      <= '0;
      credits_q  <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      ram_en_q   <= ram_en_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      tag_q      <= tag_d;
      credits_q  <= credits_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr_q] <= i_ram_dout;
  end

  // Recent write addresses: a read to one of them would reach the RAM before the write lands.
  if (WR_LATENCY > 1) begin : g_hist
    logic [HL-1:0]         hist_v_q, hist_v_d, match;
    logic [ADDR_WIDTH-1:0] hist_a_q [HL];
    logic [ADDR_WIDTH-1:0] hist_a_d [HL];

    always_comb begin
      hist_v_d[0] = accept & i_req_we;
      hist_a_d[0] = i_req_addr;
      for (int i = 1; i < HL; i++) begin
        hist_v_d[i] = hist_v_q[i-1];
        hist_a_d[i] = hist_a_q[i-1];
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        hist_v_q <= '0;
        for (int i = 0; i < HL; i++) hist_a_q[i] <= '0;
      end else begin
        hist_v_q <= hist_v_d;
        for (int i = 0; i < HL; i++) hist_a_q[i] <= hist_a_d[i];
      end
    end

    for (genvar gi = 0; gi < HL; gi++) begin : g_cmp
      assign match[gi] = hist_v_q[gi] & (hist_a_q[gi] == i_req_addr);
    end
    assign hazard   = |match;
    assign hist_any = |hist_v_q;
  end else begin : g_no_hist
    assign hazard   = 1'b0;
    assign hist_any = 1'b0;
  end

endmodule

// File: tb/tb_ram_port_master.sv
// Bench for ram_port_master: a behavioural RAM, a transaction-level reference model checked
// every cycle, and directed scenarios with hand-computed expectations.
module tb_ram_port_master;
  localparam int DW = 8, AW = 6, RDL = 2, WRL = 3, DEP = 4;
  localparam int WWIN = (WRL > 1) ? WRL - 1 : 1;

  logic          i_clk = 1'b0, i_rst_n;
  logic          i_req_valid, o_req_ready, i_req_we;
  logic [AW-1:0] i_req_addr, o_ram_addr;
  logic [DW-1:0] i_req_wdata, o_rsp_rdata, o_ram_din, i_ram_dout;
  logic          o_rsp_valid, i_rsp_ready, o_ram_en, o_ram_we, o_busy;

  ram_port_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(RDL),
                    .WR_LATENCY(WRL), .RSP_DEPTH(DEP)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
    .o_ram_en(o_ram_en), .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr),
    .o_ram_din(o_ram_din), .i_ram_dout(i_ram_dout), .o_busy(o_busy));

  always #5 i_clk = ~i_clk;

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  // ---------------- behavioural RAM (reads see only writes committed at earlier edges)
  typedef struct { int due; logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  logic [DW-1:0] ram_mem [2**AW];
  logic [DW-1:0] rd_pipe [RDL];
  wr_t           wq[$];
  int            ram_cyc = 0;

  always @(posedge i_clk) begin
    for (int k = RDL - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
    rd_pipe[0] <= (o_ram_en && !o_ram_we) ? ram_mem[o_ram_addr] : 8'hEE;
    if (o_ram_en && o_ram_we) wq.push_back('{ram_cyc + WRL - 1, o_ram_addr, o_ram_din});
    while (wq.size() > 0 && wq[0].due <= ram_cyc) begin
      ram_mem[wq[0].a] = wq[0].d;
      void'(wq.pop_front());
    end
    ram_cyc++;
  end
  assign i_ram_dout = rd_pipe[RDL-1];

  // ---------------- reference model: per-address write times, queues of reads and responses
  typedef struct { int due; logic [DW-1:0] d; } rd_t;
  logic [DW-1:0] mdl_mem [2**AW];
  int            last_wr [2**AW];
  int            last_any_wr, cyc = 0;
  rd_t           infl[$];
  logic [DW-1:0] fifo[$];
  logic          exp_en, exp_we, mdl_acc;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_din;

  function automatic logic ready_exp();
    if (!i_rst_n) return 1'b0;
    if (i_req_we) return 1'b1;
    if (infl.size() + fifo.size() >= DEP) return 1'b0;
    if (cyc - last_wr[i_req_addr] < WRL) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic busy_exp();
    return (infl.size() + fifo.size() > 0) || ((cyc - 1 - last_any_wr) < WWIN);
  endfunction

  always @(posedge i_clk) begin
    if (!i_rst_n) begin
      infl.delete();
      fifo.delete();
      for (int a = 0; a < 2**AW; a++) last_wr[a] = -1000;
      last_any_wr = -1000;
      exp_en = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_din = '0;
    end else begin
      mdl_acc = i_req_valid && ready_exp();
      if (i_rsp_ready && fifo.size() > 0) void'(fifo.pop_front());
      while (infl.size() > 0 && infl[0].due == cyc) begin
        fifo.push_back(infl[0].d);
        void'(infl.pop_front());
      end
      exp_en = mdl_acc;
      exp_we = mdl_acc && i_req_we;
      if (mdl_acc) begin
        exp_addr = i_req_addr;
        exp_din  = i_req_wdata;
        if (i_req_we) begin
          mdl_mem[i_req_addr] = i_req_wdata;
          last_wr[i_req_addr] = cyc;
          last_any_wr = cyc;
        end else begin
          infl.push_back('{cyc + RDL + 1, mdl_mem[i_req_addr]});
        end
      end
    end
    cyc++;
  end

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      chk("req_ready", o_req_ready, ready_exp());
      chk("rsp_valid", o_rsp_valid, fifo.size() > 0);
      if (fifo.size() > 0) chk("rsp_rdata", o_rsp_rdata, fifo[0]);
      chk("ram_en", o_ram_en, exp_en);
      chk("ram_we", o_ram_we, exp_we);
      chk("ram_addr", o_ram_addr, exp_addr);
      chk("ram_din", o_ram_din, exp_din);
      chk("busy", o_busy, busy_exp());
    end
  end

  logic [DW-1:0] popped[$];
  always @(negedge i_clk) begin
    if (i_rst_n && o_rsp_valid && i_rsp_ready) popped.push_back(o_rsp_rdata);
  end

  // ---------------- stimulus helpers
  task automatic cyc1();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_req_valid = 1'b0;
    i_req_we    = 1'b0;
  endtask

  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output int waited);
    logic r;
    i_req_valid = 1'b1; i_req_we = we; i_req_addr = a; i_req_wdata = d;
    waited = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge i_clk);
      r = o_req_ready;
      @(posedge i_clk);
      #1;
      if (r) return;
      waited++;
    end
    timeout("send_accept");
  endtask

  task automatic wait_rsp(input string nm, input logic [DW-1:0] exp);
    for (int t = 0; t < 40; t++) begin
      @(negedge i_clk);
      if (o_rsp_valid) begin
        chk(nm, o_rsp_rdata, exp);
        return;
      end
    end
    timeout(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [DW-1:0] e5 [6];
    for (int a = 0; a < 2**AW; a++) begin
      ram_mem[a] = DW'(a);
      mdl_mem[a] = DW'(a);
    end
    i_rst_n = 1'b0; i_req_valid = 1'b0; i_req_we = 1'b0; i_req_addr = '0;
    i_req_wdata = '0; i_rsp_ready = 1'b1;
    #2;
    chk("rst_ready", o_req_ready, 0);
    chk("rst_en", o_ram_en, 0);
    chk("rst_rsp_valid", o_rsp_valid, 0);
    chk("rst_busy", o_busy, 0);
    repeat (3) cyc1();
    i_rst_n = 1'b1;
    cyc1();

    // single read, latency and RAM-port timing
    send(1'b1, 6'h05, 8'hA5, w);
    idle();
    repeat (4) cyc1();
    send(1'b0, 6'h05, 8'h00, w);
    chk("t2_wait", w, 0);
    idle();
    chk("t2_ram_en", o_ram_en, 1);
    chk("t2_ram_we", o_ram_we, 0);
    chk("t2_ram_addr", o_ram_addr, 6'h05);
    cyc1(); chk("t2_valid_e1", o_rsp_valid, 0);
    cyc1(); chk("t2_valid_e2", o_rsp_valid, 0);
    cyc1(); chk("t2_valid_e3", o_rsp_valid, 1);
    chk("t2_rdata", o_rsp_rdata, 8'hA5);

    // read-after-write spacing
    repeat (4) cyc1();
    send(1'b1, 6'h10, 8'h3C, w);
    send(1'b0, 6'h10, 8'h00, w);
    chk("t3_blocked_cycles", w, 2);
    idle();
    wait_rsp("t3_rdata", 8'h3C);
    repeat (3) cyc1();
    send(1'b1, 6'h10, 8'h3D, w);
    send(1'b0, 6'h11, 8'h00, w);
    chk("t3_other_addr_wait", w, 0);
    idle();
    wait_rsp("t3_rdata_11", 8'h11);

    // credit stall with interleaved write, then in-order drain
    repeat (6) cyc1();
    send(1'b1, 6'h05, 8'h05, w);
    idle();
    i_rsp_ready = 1'b0;
    repeat (4) cyc1();
    popped.delete();
    for (int i = 0; i < 4; i++) begin
      send(1'b0, AW'(i), 8'h00, w);
      chk($sformatf("t4_rd%0d_wait", i), w, 0);
    end
    i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 6'h04;
    for (int i = 0; i < 2; i++) begin
      @(negedge i_clk);
      chk("t4_stall_ready", o_req_ready, 0);
      @(posedge i_clk);
      #1;
    end
    i_req_we = 1'b1; i_req_addr = 6'h20; i_req_wdata = 8'h77;
    @(negedge i_clk);
    chk("t4_wr_ready", o_req_ready, 1);
    @(posedge i_clk);
    #1;
    i_rsp_ready = 1'b1;
    send(1'b0, 6'h04, 8'h00, w);
    send(1'b0, 6'h05, 8'h00, w);
    idle();
    repeat (12) cyc1();
    chk("t4_npop", popped.size(), 6);
    for (int i = 0; i < popped.size() && i < 6; i++)
      chk($sformatf("t4_pop%0d", i), popped[i], DW'(i));

    // full FIFO: pop frees a credit, then pop and accept coincide
    popped.delete();
    i_rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b0, AW'(i), 8'h00, w);
    idle();
    repeat (5) cyc1();
    chk("t5_full_valid", o_rsp_valid, 1);
    i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 6'h01;
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    chk("t5_full_ready", o_req_ready, 0);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    chk("t5_ready_after_pop", o_req_ready, 1);
    @(posedge i_clk); #1;
    i_req_addr = 6'h02;
    @(negedge i_clk);
    chk("t5_credits_held", o_req_ready, 1);
    @(posedge i_clk); #1;
    idle();
    repeat (12) cyc1();
    e5 = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h01, 8'h02};
    chk("t5_npop", popped.size(), 6);
    for (int i = 0; i < popped.size() && i < 6; i++)
      chk($sformatf("t5_pop%0d", i), popped[i], e5[i]);

    // asynchronous reset with reads in flight and a queued response
    repeat (4) cyc1();
    i_rsp_ready = 1'b0;
    send(1'b0, 6'h00, 8'h00, w);
    idle();
    cyc1();
    send(1'b0, 6'h01, 8'h00, w);
    send(1'b0, 6'h02, 8'h00, w);
    idle();
    chk("t1_pre_valid", o_rsp_valid, 1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("t1_en", o_ram_en, 0);
    chk("t1_we", o_ram_we, 0);
    chk("t1_addr", o_ram_addr, 0);
    chk("t1_din", o_ram_din, 0);
    chk("t1_valid", o_rsp_valid, 0);
    chk("t1_rdata", o_rsp_rdata, 0);
    chk("t1_busy", o_busy, 0);
    chk("t1_ready", o_req_ready, 0);
    repeat (2) cyc1();
    i_rst_n = 1'b1;
    i_rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc1();
      chk("t1_dropped_valid", o_rsp_valid, 0);
    end
    send(1'b0, 6'h03, 8'h00, w);
    idle();
    wait_rsp("t1_new_read", 8'h03);

    // alternating write/read to distinct addresses at full rate
    repeat (6) cyc1();
    popped.delete();
    for (int i = 0; i < 8; i++) begin
      send(1'b1, AW'(8'h30 + i), DW'(8'h50 + i), w);
      chk("t6_wr_wait", w, 0);
      chk("t6_busy_wr", o_busy, 1);
      send(1'b0, AW'(8'h38 + i), 8'h00, w);
      chk("t6_rd_wait", w, 0);
      chk("t6_busy_rd", o_busy, 1);
    end
    idle();
    w = 0;
    while (popped.size() < 8 && w < 40) begin
      @(negedge i_clk);
      #1;
      w++;
    end
    if (popped.size() < 8) timeout("t6_drain");
    else begin
      chk("t6_busy_last_pop", o_busy, 1);
      @(posedge i_clk); #1;
      chk("t6_busy_end", o_busy, 0);
      for (int i = 0; i < 8; i++)
        chk($sformatf("t6_pop%0d", i), popped[i], DW'(8'h38 + i));
    end
    repeat (3) cyc1();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
